// File: rtl/drop_turn_ctrl_if.sv
// drop_turn_ctrl_if: handshake bundle between the Connect4 move source and drop_turn_ctrl
// master drives start/drop_req/col_sel; slave (drop_turn_ctrl) drives turn, animation, commit and status outputs
interface drop_turn_ctrl_if;
  logic       start;
  logic       drop_req;
  logic [2:0] col_sel;
  logic       player;
  logic       drop_ack;
  logic       drop_reject;
  logic       anim_valid;
  logic [2:0] anim_row;
  logic [2:0] anim_col;
  logic       place_valid;
  logic [2:0] place_row;
  logic [2:0] place_col;
  logic       place_player;
  logic [3:0] time_left;
  logic       timeout;
  logic       board_full;
  logic       busy;
  modport master (
    output start, drop_req, col_sel,
    input  player, drop_ack, drop_reject, anim_valid, anim_row, anim_col,
           place_valid, place_row, place_col, place_player, time_left, timeout, board_full, busy
  );
  modport slave (
    input  start, drop_req, col_sel,
    output player, drop_ack, drop_reject, anim_valid, anim_row, anim_col,
           place_valid, place_row, place_col, place_player, time_left, timeout, board_full, busy
  );
endinterface

// File: rtl/drop_turn_ctrl.sv
// drop_turn_ctrl: Connect4 turn arbiter with per-turn timeout and one-row-per-tick piece drop animation
// clk_in/rst: system clock and synchronous active-high reset
// bus (slave): start, drop_req, col_sel in; player, drop_ack, drop_reject, anim_*, place_*, time_left, timeout, board_full, busy out
module drop_turn_ctrl #(
  parameter int TICK_DIV   = 65000000,
  parameter int ROWS       = 6,
  parameter int COLS       = 7,
  parameter int TURN_TICKS = 10
) (
  input logic            clk_in,
  input logic            rst,
  drop_turn_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_MOVE, DROP, COMMIT, FULL} state_t;
  typedef struct packed {
    logic       player;
    logic       drop_ack;
    logic       drop_reject;
    logic       anim_valid;
    logic [2:0] anim_row;
    logic [2:0] anim_col;
    logic       place_valid;
    logic [2:0] place_row;
    logic [2:0] place_col;
    logic       place_player;
    logic [3:0] time_left;
    logic       timeout;
    logic       board_full;
  } out_t;
  state_t      state, state_n;
  out_t        o, o_n;
  logic [27:0] cnt, cnt_n;
  logic [3:0]  height [8];
  logic [3:0]  height_n [8];
  logic [6:0]  moves, moves_n;
  logic [2:0]  target, target_n;
  logic        tick, legal;
  assign tick = cnt == 28'(TICK_DIV - 1);
  // eight height entries so any 3-bit col_sel indexes safely; the COLS compare rejects the spare ones
  assign legal = ({1'b0, bus.col_sel} < 4'(COLS)) && (height[bus.col_sel] < 4'(ROWS));
  always_ff @(posedge clk_in)
    if (rst) begin
      state  <= IDLE;
      o      <= '0;
      cnt    <= '0;
      height <= '{default: '0};
      moves  <= '0;
      target <= '0;
    end else begin
      state  <= state_n;
      o      <= o_n;
      cnt    <= cnt_n;
      height <= height_n;
      moves  <= moves_n;
      target <= target_n;
    end
  always_comb begin
    state_n         = state;
    o_n             = o;
    o_n.drop_ack    = 1'b0;
    o_n.drop_reject = 1'b0;
    o_n.place_valid = 1'b0;
    o_n.timeout     = 1'b0;
    cnt_n           = tick ? '0 : cnt + 28'd1;
    height_n        = height;
    moves_n         = moves;
    target_n        = target;
    if ((state == IDLE || state == FULL) && bus.start) begin
      state_n        = WAIT_MOVE;
      cnt_n          = '0;
      height_n       = '{default: '0};
      moves_n        = '0;
      o_n.player     = 1'b0;
      o_n.time_left  = 4'(TURN_TICKS);
      o_n.board_full = 1'b0;
    end else if (state == WAIT_MOVE && bus.drop_req && legal) begin
      // a legal move beats an expiring tick in the same cycle; the timer freezes for the drop
      state_n        = DROP;
      cnt_n          = '0;
      target_n       = 3'(4'(ROWS - 1) - height[bus.col_sel]);
      o_n.drop_ack   = 1'b1;
      o_n.anim_valid = 1'b1;
      o_n.anim_row   = 3'd0;
      o_n.anim_col   = bus.col_sel;
    end else if (state == WAIT_MOVE) begin
      o_n.drop_reject = bus.drop_req;
      if (tick && o.time_left == 4'd1) begin
        o_n.timeout   = 1'b1;
        o_n.player    = ~o.player;
        o_n.time_left = 4'(TURN_TICKS);
      end else if (tick)
        o_n.time_left = o.time_left - 4'd1;
    end else if (state == DROP && tick) begin
      if (o.anim_row == target) begin
        state_n          = COMMIT;
        o_n.place_valid  = 1'b1;
        o_n.place_row    = target;
        o_n.place_col    = o.anim_col;
        o_n.place_player = o.player;
      end else
        o_n.anim_row = o.anim_row + 3'd1;
    end else if (state == COMMIT) begin
      height_n[o.anim_col] = height[o.anim_col] + 4'd1;
      moves_n              = moves + 7'd1;
      o_n.anim_valid       = 1'b0;
      if (moves_n == 7'(ROWS * COLS)) begin
        state_n        = FULL;
        o_n.board_full = 1'b1;
      end else begin
        state_n       = WAIT_MOVE;
        cnt_n         = '0;
        o_n.player    = ~o.player;
        o_n.time_left = 4'(TURN_TICKS);
      end
    end
  end
  assign bus.player       = o.player;
  assign bus.drop_ack     = o.drop_ack;
  assign bus.drop_reject  = o.drop_reject;
  assign bus.anim_valid   = o.anim_valid;
  assign bus.anim_row     = o.anim_row;
  assign bus.anim_col     = o.anim_col;
  assign bus.place_valid  = o.place_valid;
  assign bus.place_row    = o.place_row;
  assign bus.place_col    = o.place_col;
  assign bus.place_player = o.place_player;
  assign bus.time_left    = o.time_left;
  assign bus.timeout      = o.timeout;
  assign bus.board_full   = o.board_full;
  assign bus.busy         = state == DROP || state == COMMIT;
endmodule

// File: tb/tb_drop_turn_ctrl.sv
// tb_drop_turn_ctrl: randomized scoreboard bench for drop_turn_ctrl (TICK_DIV=4, 6x7 board, 3-tick turns)
module tb_drop_turn_ctrl;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  always #5 clk_in = ~clk_in;
  drop_turn_ctrl_if bus();
  drop_turn_ctrl #(.TICK_DIV(4), .ROWS(6), .COLS(7), .TURN_TICKS(3)) dut (.clk_in(clk_in), .rst(rst), .bus(bus));
  typedef struct {
    int     kind;
    int     row;
    int     col;
    int     plr;
    longint cyc;
  } ev_t;
  ev_t    q[$];
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  longint ack_cyc = 0;
  int     h[7];
  bit     plr;
  int     moves;
  bit     full;
  int     w;
  bit     pend;
  int     tgt;
  int     pcol;
  always @(posedge clk_in) cyc <= cyc + 1;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  function automatic void push(int k, int r, int c, int p, longint t);
    ev_t e;
    e.kind = k;
    e.row  = r;
    e.col  = c;
    e.plr  = p;
    e.cyc  = t;
    q.push_back(e);
  endfunction
  function automatic void pop_chk(int k);
    ev_t e;
    if (q.size() == 0) begin
      chk($sformatf("unexpected_event_kind%0d", k), 1, 0);
      return;
    end
    e = q.pop_front();
    chk("event_kind", k, e.kind);
    chk("event_cycle", cyc, e.cyc);
    if (k == 0) begin
      chk("ack_anim_row", bus.anim_row, 0);
      chk("ack_anim_col", bus.anim_col, e.col);
      chk("ack_anim_valid", bus.anim_valid, 1);
      chk("ack_player", bus.player, e.plr);
    end else if (k == 1)
      chk("reject_player", bus.player, e.plr);
    else if (k == 2) begin
      chk("timeout_player", bus.player, e.plr);
      chk("timeout_time_left", bus.time_left, 3);
    end else begin
      chk("place_row", bus.place_row, e.row);
      chk("place_col", bus.place_col, e.col);
      chk("place_player", bus.place_player, e.plr);
    end
  endfunction
  always @(negedge clk_in)
    if (!rst) begin
      if (bus.drop_ack) begin
        ack_cyc = cyc;
        pop_chk(0);
      end
      if (bus.drop_reject) pop_chk(1);
      if (bus.timeout) pop_chk(2);
      if (bus.place_valid) pop_chk(3);
      if (bus.busy && !bus.place_valid) begin
        chk("anim_row", bus.anim_row, (cyc - ack_cyc) / 4);
        chk("anim_valid", bus.anim_valid, 1);
      end
    end
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    bus.drop_req = 1'b0;
    step();
    bus.start = 1'b0;
    foreach (h[i]) h[i] = 0;
    plr = 1'b0;
    moves = 0;
    full = 1'b0;
    w = 0;
  endtask
  task automatic req_cycle(input bit req, input int c);
    bit v;
    bit expire;
    longint t;
    chk("player", bus.player, plr);
    chk("time_left", bus.time_left, 3 - (w % 12) / 4);
    chk("busy_idle", bus.busy, 0);
    chk("board_full_idle", bus.board_full, 0);
    chk("anim_valid_idle", bus.anim_valid, 0);
    v = req && c < 7;
    if (v) v = h[c] < 6;
    expire = (w % 12 == 11) && !v;
    t = cyc + 1;
    bus.drop_req = req;
    bus.col_sel = 3'(c);
    bus.start = $urandom_range(0, 7) == 0;
    if (v) begin
      pend = 1'b1;
      tgt = 5 - h[c];
      pcol = c;
      push(0, 0, c, plr, t);
      push(3, tgt, c, plr, t + 4 * (tgt + 1));
    end else begin
      pend = 1'b0;
      if (expire) plr = ~plr;
      if (req) push(1, 0, c, plr, t);
      if (expire) push(2, 0, 0, plr, t);
      w++;
    end
    step();
    bus.drop_req = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic run_drop();
    repeat (4 * tgt + 5) begin
      bus.drop_req = 1'($urandom_range(0, 1));
      bus.col_sel = 3'($urandom_range(0, 7));
      bus.start = $urandom_range(0, 3) == 0;
      step();
    end
    bus.drop_req = 1'b0;
    bus.start = 1'b0;
    h[pcol]++;
    moves++;
    w = 0;
    if (moves == 42) full = 1'b1;
    else plr = ~plr;
  endtask
  task automatic turn(input int d, input int c);
    repeat (d) req_cycle(1'b0, 0);
    req_cycle(1'b1, c);
    if (pend) run_drop();
  endtask
  task automatic full_idle(input int n);
    repeat (n) begin
      chk("full_flag", bus.board_full, 1);
      chk("full_busy", bus.busy, 0);
      bus.drop_req = 1'b1;
      bus.col_sel = 3'($urandom_range(0, 7));
      step();
    end
    bus.drop_req = 1'b0;
  endtask
  function automatic int pick();
    int c;
    if ($urandom_range(0, 9) == 0) return $urandom_range(0, 7);
    do c = $urandom_range(0, 6); while (h[c] >= 6);
    return c;
  endfunction
  function automatic logic [24:0] outs();
    return {bus.player, bus.drop_ack, bus.drop_reject, bus.anim_valid, bus.anim_row, bus.anim_col,
            bus.place_valid, bus.place_row, bus.place_col, bus.place_player, bus.time_left,
            bus.timeout, bus.board_full, bus.busy};
  endfunction
  initial begin
    bus.start = 1'b0;
    bus.drop_req = 1'b0;
    bus.col_sel = 3'd0;
    repeat (3) step();
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    do_start();
    turn(0, 3);
    repeat (6) turn(0, 0);
    turn(0, 0);
    turn(0, 7);
    repeat (14) req_cycle(1'b0, 0);
    turn((11 - w % 12 + 12) % 12, 1);
    while (!full) turn($urandom_range(0, 13), pick());
    full_idle(8);
    do_start();
    repeat (3) turn($urandom_range(0, 5), pick());
    req_cycle(1'b1, 2);
    repeat (9) step();
    chk("abort_anim_row", bus.anim_row, 2);
    rst = 1'b1;
    step();
    chk("abort_outputs", outs(), 0);
    q.delete();
    step();
    chk("abort_hold_outputs", outs(), 0);
    rst = 1'b0;
    step();
    do_start();
    turn(0, 2);
    turn(1, 2);
    turn($urandom_range(0, 13), pick());
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/drop_turn_ctrl.md
Name: drop_turn_ctrl

Overview:
- Turn and piece-drop sequencer for the Connect4 game.
- Derives its own slow timebase as a single-cycle tick enable from clk_in; no derived clock is generated.
- Arbitrates moves between player 0 and player 1, enforces a per-turn timeout and animates each falling piece one row per tick.
- Emits a commit pulse consumed by the board memory and win-check logic, which are outside this block.

Parameters:
- TICK_DIV, 65000000, clk_in cycles per animation/timer tick (≥2)
- ROWS, 6, board rows (≤8)
- COLS, 7, board columns (≤8)
- TURN_TICKS, 10, ticks allowed per turn (1..15)

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a new game from IDLE or FULL
- drop_req  in  1  pulse; current player requests a drop
- col_sel  in  3  requested column, 0..COLS-1
- player  out  1  player whose turn it is
- drop_ack  out  1  1-cycle pulse; request accepted
- drop_reject  out  1  1-cycle pulse; request refused
- anim_valid  out  1  falling piece is being shown
- anim_row  out  3  current row of falling piece, 0 = top
- anim_col  out  3  column of falling piece
- place_valid  out  1  1-cycle commit pulse
- place_row  out  3  committed row
- place_col  out  3  committed column
- place_player  out  1  owner of committed piece
- time_left  out  4  ticks remaining in turn
- timeout  out  1  1-cycle pulse; turn forfeited
- board_full  out  1  all ROWS*COLS cells used
- busy  out  1  state is DROP or COMMIT

Behaviour:
- Reset, on the rst edge regardless of state:
  - State goes to IDLE; tick counter, move counter and all column heights are cleared.
  - Every output is 0.
  - rst applies mid-DROP or mid-COMMIT with no place_valid emitted.
- Tick generation:
  - 28-bit counter; tick=1 when count==TICK_DIV-1, and count wraps to 0 on the same edge.
  - The counter is cleared on entry to WAIT_MOVE and on entry to DROP, so the first tick arrives exactly TICK_DIV cycles after entry.
- IDLE:
  - start → WAIT_MOVE; player=0, time_left=TURN_TICKS, heights and move counter cleared.
  - All other inputs are ignored.
- WAIT_MOVE, on drop_req:
  - Valid request (col_sel<COLS and height[col_sel]<ROWS): next cycle drop_ack=1, anim_col=col_sel, anim_row=0, anim_valid=1, target=ROWS-1-height; go to DROP.
  - Invalid request: next cycle drop_reject=1; state, player and timer are unchanged.
- WAIT_MOVE, on tick:
  - time_left decrements.
  - If time_left==1 at the tick: timeout=1, player toggles, time_left=TURN_TICKS, state stays WAIT_MOVE.
  - A valid drop_req in the same cycle as the expiring tick wins: no timeout, the drop proceeds.
  - An invalid drop_req in that cycle does not block the timeout; both pulses are asserted.
- DROP:
  - On each tick: if anim_row==target → COMMIT; else anim_row+1.
  - Drop latency from drop_ack to entering COMMIT is (target+1)*TICK_DIV cycles.
  - drop_req is ignored with no pulses; time_left is frozen.
- COMMIT, one cycle:
  - place_valid=1 with place_row=target, place_col=anim_col, place_player=player.
  - height[col]+1, move counter+1, anim_valid→0.
  - If the move counter reaches ROWS*COLS: → FULL with board_full=1.
  - Otherwise: player toggles, time_left=TURN_TICKS → WAIT_MOVE.
- FULL:
  - board_full held at 1; drop_req is ignored.
  - start restarts exactly as from IDLE and clears board_full.
- start in WAIT_MOVE, DROP or COMMIT is ignored; only rst aborts a game.
- Width rules:
  - Per-column height is 4 bits; move counter is 7 bits.
  - col_sel is compared as unsigned 3 bits; values ≥COLS are rejected.
- Registered outputs: place_* and anim_* hold their last value when their valid signal is low.

Test Plan:
All scenarios use TICK_DIV=4, ROWS=6, COLS=7, TURN_TICKS=3.
1. Reset then start → all outputs 0 during reset; one cycle after start, player=0, time_left=3, busy=0.
2. drop_req col_sel=3 on an empty board → drop_ack next cycle; anim_row steps 0,1,2,3,4,5 every 4 cycles; place_valid with row=5, col=3, player=0; then player=1 and time_left=3.
3. Six valid drops into column 0, then drop_req col 0 → drop_reject pulse, player unchanged. drop_req col_sel=7 → drop_reject pulse.
4. No requests for 12 cycles after entering WAIT_MOVE → time_left 3→2→1; timeout pulse on the 3rd tick; player toggles; time_left=3. A valid drop_req coincident with the 3rd tick → drop_ack, no timeout.
5. 42 valid drops filling the board → board_full=1 after the final place_valid; a further drop_req gives no ack or reject; start → board_full=0, player=0, heights cleared.
6. rst asserted while anim_row=2 in DROP → next cycle state is IDLE, all outputs 0, no place_valid; after start, column heights are 0.
